// File: rtl/logic_bitmanip_unit_if.sv
// Operand/result handshake bundle for logic_bitmanip_unit.
// master = issuing pipeline stage and result consumer; slave = the unit.
interface logic_bitmanip_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic [3:0]       op_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] Result_o;

  modport master (
    output valid_i, A_i, B_i, op_i, ready_i,
    input  ready_o, valid_o, Result_o
  );

  modport slave (
    input  valid_i, A_i, B_i, op_i, ready_i,
    output ready_o, valid_o, Result_o
  );
endinterface

// File: rtl/logic_bitmanip_unit.sv
// Logic ops (latency 1) and iterative CLZ/CTZ/CPOP (latency WIDTH/CHUNK+... fixed) behind one output register.
// Backpressure: ready_o drops while iterating or while a result is held; LU_ROTATE_EN adds ROL/ROR.
module logic_bitmanip_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  logic_bitmanip_unit_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int ACCW   = $clog2(WIDTH) + 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SHW    = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ANDN = 4'b0011;
  localparam logic [3:0] OP_ORN  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_CLZ  = 4'b0110;
  localparam logic [3:0] OP_CTZ  = 4'b0111;
  localparam logic [3:0] OP_CPOP = 4'b1000;
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;

  typedef enum logic [0:0] {S_IDLE, S_ITER} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [ACCW-1:0]  r_acc, w_acc_nxt;
  logic             r_found, w_found_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [3:0]       r_op, w_op_nxt;
  logic             r_valid, w_valid_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;

  logic             w_ready;
  logic             w_accept;
  logic             w_is_iter;
  logic             w_last;
  logic [CW-1:0]    w_idx;
  logic [WIDTH-1:0] w_shift;
  logic [CHUNK-1:0] w_chunk;
  logic [ACCW-1:0]  w_lz, w_tz, w_pop;
  logic [ACCW-1:0]  w_acc_step;
  logic             w_found_step;

  function automatic logic [ACCW-1:0] f_lz(input logic [CHUNK-1:0] c);
    logic [ACCW-1:0] n;
    n = ACCW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (c[i]) n = ACCW'(CHUNK - 1 - i);
    end
    return n;
  endfunction

  function automatic logic [ACCW-1:0] f_tz(input logic [CHUNK-1:0] c);
    logic [ACCW-1:0] n;
    n = ACCW'(CHUNK);
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) n = ACCW'(i);
    end
    return n;
  endfunction

  function automatic logic [ACCW-1:0] f_pop(input logic [CHUNK-1:0] c);
    logic [ACCW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + ACCW'(c[i]);
    end
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] f_single(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
`ifdef LU_ROTATE_EN
    logic [2*WIDTH-1:0] dbl;
    logic [SHW-1:0]     sh;
    sh  = b[SHW-1:0];
    dbl = '0;
`endif
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_ANDN: res = a & ~b;
      OP_ORN:  res = a | ~b;
      OP_XNOR: res = ~(a ^ b);
`ifdef LU_ROTATE_EN
      // Rotating a doubled copy keeps the wrap-around bits without a variable-width shift.
      OP_ROL: begin
        dbl = {a, a} << sh;
        res = dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dbl = {a, a} >> sh;
        res = dbl[WIDTH-1:0];
      end
`endif
      default: res = '0;
    endcase
    return res;
  endfunction

  assign w_ready   = (r_state == S_IDLE) && (!r_valid || bus.ready_i);
  assign w_accept  = bus.valid_i && w_ready;
  assign w_is_iter = (bus.op_i == OP_CLZ) || (bus.op_i == OP_CTZ) || (bus.op_i == OP_CPOP);
  assign w_last    = (r_cnt == CW'(NCHUNK - 1));

  // CLZ walks chunks from the top; CTZ and CPOP walk from the bottom.
  assign w_idx   = (r_op == OP_CLZ) ? (CW'(NCHUNK - 1) - r_cnt) : r_cnt;
  assign w_shift = r_a >> (int'(w_idx) * CHUNK);
  assign w_chunk = w_shift[CHUNK-1:0];
  assign w_lz    = f_lz(w_chunk);
  assign w_tz    = f_tz(w_chunk);
  assign w_pop   = f_pop(w_chunk);

  always_comb begin
    w_acc_step   = r_acc;
    w_found_step = r_found;
    case (r_op)
      OP_CLZ: begin
        if (!r_found) begin
          w_acc_step   = r_acc + w_lz;
          w_found_step = |w_chunk;
        end
      end
      OP_CTZ: begin
        if (!r_found) begin
          w_acc_step   = r_acc + w_tz;
          w_found_step = |w_chunk;
        end
      end
      OP_CPOP: w_acc_step = r_acc + w_pop;
      default: w_acc_step = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_found_nxt  = r_found;
    w_a_nxt      = r_a;
    w_op_nxt     = r_op;
    w_valid_nxt  = r_valid;
    w_result_nxt = r_result;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      if (r_valid && bus.ready_i) w_valid_nxt = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_iter) begin
              w_state_nxt = S_ITER;
              w_a_nxt     = bus.A_i;
              w_op_nxt    = bus.op_i;
              w_acc_nxt   = '0;
              w_found_nxt = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_result_nxt = f_single(bus.op_i, bus.A_i, bus.B_i);
              w_valid_nxt  = 1'b1;
            end
          end
        end
        S_ITER: begin
          w_acc_nxt   = w_acc_step;
          w_found_nxt = w_found_step;
          if (w_last) begin
            w_result_nxt = {{(WIDTH-ACCW){1'b0}}, w_acc_step};
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_found  <= 1'b0;
      r_a      <= '0;
      r_op     <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_found  <= w_found_nxt;
      r_a      <= w_a_nxt;
      r_op     <= w_op_nxt;
      r_valid  <= w_valid_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = r_valid;
  assign bus.Result_o = r_result;

endmodule
